pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, width of every address port.
REQ-002 SHALL have parameter RESET_ADDR, default 0, PC value loaded by reset.
REQ-003 SHALL have parameter EXC_ADDR, default 10'h3F0, exception vector.
REQ-004 SHALL have parameter STEP, default 1, sequential increment in instruction-memory words.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 stall  input  1  hazard unit: hold PC.
REQ-009 branch_taken  input  1  EX-stage branch resolved taken.
REQ-010 branch_target  input  ADDR_WIDTH  branch destination.
REQ-011 jump  input  1  ID-stage jump.
REQ-012 jump_target  input  ADDR_WIDTH  jump destination.
REQ-013 exception  input  1  trap request.
REQ-014 halt  input  1  halt instruction decoded.
REQ-015 resume  input  1  external restart from HALTED.
REQ-016 PC_current  output  ADDR_WIDTH  fetch address to instruction memory.
REQ-017 PC_seq  output  ADDR_WIDTH  combinational PC_current+STEP, for link registers.
REQ-018 fetch_valid  output  1  PC_current is a real fetch this cycle.
REQ-019 epc  output  ADDR_WIDTH  PC_current captured on exception.
REQ-020 halted  output  1  high in HALTED state.

Function
REQ-021 SHALL implement FSM states BOOT, RUN, HALTED; all transitions on rising clock edge.
REQ-022 BOOT: PC_current holds RESET_ADDR, fetch_valid=0; next state RUN unconditionally (exactly one cycle).
REQ-023 RUN: fetch_valid=1; next PC chosen by fixed priority: exception, branch_taken, jump, stall, halt, sequential.
REQ-024 exception SHALL load EXC_ADDR and latch epc<=PC_current, regardless of stall or state (BOOT excepted).
REQ-025 branch_taken SHALL load branch_target even when stall=1.
REQ-026 jump SHALL load jump_target only when stall=0; with stall=1 jump is ignored and PC holds.
REQ-027 stall alone SHALL hold PC_current unchanged.
REQ-028 halt (no higher-priority event) SHALL hold PC_current and enter HALTED next cycle.
REQ-029 sequential SHALL load PC_current+STEP, truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH, no error flag).
REQ-030 HALTED: fetch_valid=0, PC_current held; resume -> RUN with PC_current+STEP; exception -> RUN with EXC_ADDR and epc update; all other inputs ignored.
REQ-031 PC_seq SHALL equal PC_current+STEP mod 2^ADDR_WIDTH in every state.
REQ-032 halted SHALL be registered state decode, glitch-free; input changes SHALL affect PC_current only at the next edge (latency 1 cycle).

Reset
REQ-033 reset_n=0 SHALL immediately force state=BOOT, PC_current=RESET_ADDR, epc=0, fetch_valid=0, halted=0, independent of clock.
REQ-034 reset asserted mid-operation (any state, any pending event) SHALL discard the event; release re-enters BOOT for one cycle.

Verification
REQ-035 Reset release, no events, defaults: PC_current 0 (BOOT, fetch_valid=0), then 0,1,2,3 with fetch_valid=1.
REQ-036 PC=0x3FF sequential -> PC=0x000, no other effect; PC_seq at 0x3FF reads 0x000.
REQ-037 PC=0x10, stall=1, jump=1 target 0x80 -> PC stays 0x10; same cycle plus branch_taken target 0x40 -> PC=0x40.
REQ-038 PC=0x22, exception+branch_taken+halt together -> PC=0x3F0, epc=0x22, state RUN.
REQ-039 PC=0x05, halt -> halted=1, PC holds 0x05 with fetch_valid=0 for 3 cycles; resume -> PC=0x06, halted=0.
REQ-040 reset_n pulsed low between edges while PC=0x55 -> PC_current=0 before next edge; following edges 0 (BOOT), 1.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALTED sequencing, fixed-priority redirect
// selection (exception > branch > jump > stall > halt > sequential) and EPC capture.
module pc_unit #(
  parameter int unsigned                   ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0]         RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0]         EXC_ADDR   = 10'h3F0,
  parameter int unsigned                   STEP       = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  exception,
  input  logic                  halt,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] PC_current,
  output logic [ADDR_WIDTH-1:0] PC_seq,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic                    fetch_valid_q;
  logic                    halted_q;
  logic [ADDR_WIDTH-1:0]   pc_seq;

  // Addition is done at ADDR_WIDTH, so the carry out is dropped and the PC wraps.
  assign pc_seq = pc_q + ADDR_WIDTH'(STEP);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (exception) begin
          pc_d  = EXC_ADDR;
          epc_d = pc_q;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (jump && !stall) begin
          pc_d = jump_target;
        end else if (stall || jump) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = HALTED;
        end else begin
          pc_d = pc_seq;
        end
      end
      HALTED: begin
        if (exception) begin
          state_d = RUN;
          pc_d    = EXC_ADDR;
          epc_d   = pc_q;
        end else if (resume) begin
          state_d = RUN;
          pc_d    = pc_seq;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_ADDR;
      end
    endcase
  end

  // Status flags are flopped from the next state so they come straight off a
  // register rather than through a decode of the encoded state.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_ADDR;
      epc_q         <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      fetch_valid_q <= (state_d == RUN);
      halted_q      <= (state_d == HALTED);
    end
  end

  assign PC_current  = pc_q;
  assign PC_seq      = pc_seq;
  assign fetch_valid = fetch_valid_q;
  assign epc         = epc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: boot sequence, wrap, redirect priorities,
// halt/resume, exception from HALTED and asynchronous mid-run reset.
module tb_pc_unit;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall, branch_taken, jump, exception, halt, resume;
  logic [AW-1:0] branch_target, jump_target;
  logic [AW-1:0] PC_current, PC_seq, epc;
  logic          fetch_valid, halted;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .exception     (exception),
    .halt          (halt),
    .resume        (resume),
    .PC_current    (PC_current),
    .PC_seq        (PC_seq),
    .fetch_valid   (fetch_valid),
    .epc           (epc),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; jump = 0; exception = 0; halt = 0; resume = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic jump_to(input logic [AW-1:0] a);
    jump = 1; jump_target = a;
    step();
    jump = 0;
    check("jump_to", 32'(PC_current), 32'(a));
  endtask

  task automatic check_state(input string tag, input logic [AW-1:0] pc,
                             input logic fv, input logic h);
    check({tag, "_pc"}, 32'(PC_current), 32'(pc));
    check({tag, "_fv"}, 32'(fetch_valid), 32'(fv));
    check({tag, "_halted"}, 32'(halted), 32'(h));
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    #3;
    check_state("in_reset", 10'h000, 0, 0);
    check("in_reset_epc", 32'(epc), 32'h0);
    #9 reset_n = 1;               // released between edges
    #1;
    check_state("boot", 10'h000, 0, 0);
    check("boot_seq", 32'(PC_seq), 32'h1);

    // Boot cycle then sequential fetch 0,1,2,3
    step(); check_state("run0", 10'h000, 1, 0);
    step(); check_state("run1", 10'h001, 1, 0);
    step(); check_state("run2", 10'h002, 1, 0);
    step(); check_state("run3", 10'h003, 1, 0);

    // Wrap at top of address space
    jump_to(10'h3FF);
    check("seq_at_3ff", 32'(PC_seq), 32'h000);
    step(); check_state("wrap", 10'h000, 1, 0);
    check("wrap_epc", 32'(epc), 32'h0);

    // Stall masks jump; branch overrides stall
    jump_to(10'h010);
    stall = 1; jump = 1; jump_target = 10'h080;
    step(); check("stall_jump", 32'(PC_current), 32'h010);
    branch_taken = 1; branch_target = 10'h040;
    step(); check("branch_over_stall", 32'(PC_current), 32'h040);
    clear_inputs();
    stall = 1;
    step(); check("stall_only", 32'(PC_current), 32'h040);
    stall = 0;

    // Exception beats branch and halt
    jump_to(10'h022);
    exception = 1; branch_taken = 1; branch_target = 10'h100; halt = 1;
    step(); clear_inputs();
    check_state("exc", 10'h3F0, 1, 0);
    check("exc_epc", 32'(epc), 32'h022);
    step(); check("after_exc", 32'(PC_current), 32'h3F1);

    // Halt, ignored inputs, resume
    jump_to(10'h005);
    halt = 1;
    step(); halt = 0;
    check_state("halt0", 10'h005, 0, 1);
    jump = 1; jump_target = 10'h123; branch_taken = 1; branch_target = 10'h321;
    for (int i = 1; i <= 3; i++) begin
      step(); check_state($sformatf("halt%0d", i), 10'h005, 0, 1);
    end
    clear_inputs();
    resume = 1;
    step(); resume = 0;
    check_state("resume", 10'h006, 1, 0);

    // Exception from HALTED
    halt = 1;
    step(); halt = 0;
    check_state("halt_b", 10'h006, 0, 1);
    exception = 1;
    step(); exception = 0;
    check_state("halt_exc", 10'h3F0, 1, 0);
    check("halt_exc_epc", 32'(epc), 32'h006);

    // Asynchronous reset between edges, with a pending exception
    jump_to(10'h055);
    exception = 1;
    #2 reset_n = 0;
    #1;
    check_state("async_rst", 10'h000, 0, 0);
    check("async_rst_epc", 32'(epc), 32'h0);
    #1 reset_n = 1;
    #1;
    check_state("reboot", 10'h000, 0, 0);
    step();                       // BOOT edge: exception must be ignored
    exception = 0;
    check_state("reboot_run0", 10'h000, 1, 0);
    check("reboot_epc", 32'(epc), 32'h0);
    step(); check_state("reboot_run1", 10'h001, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
